// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS data-memory bridge.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} dmem_state_e;
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/dmem_bus_bridge_timeout_ctr.sv
// dmem_timeout_ctr: counts cycles since clear; expired flags the TIMEOUT_CYCLES-th counted cycle.
module dmem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: stalls the single-cycle core while its lw/sw runs as a valid/ready bus transaction.
// Optional DMEM_TIMEOUT_EN bounds WAIT_RSP and raises a sticky bus_err.
module dmem_bus_bridge
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_rd,
  input  logic          core_wr,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_req_we,
  output logic [AW-1:0] bus_req_addr,
  output logic [DW-1:0] bus_req_wdata,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_data,
  output logic          bus_err
);
  dmem_state_e state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q, rdata_d;
  logic          access, capture, rsp_take, timeout;
  assign access   = core_rd | core_wr;
  assign capture  = state_q == IDLE && access;
  assign rsp_take = bus_rsp_valid && ((state_q == REQ && bus_req_ready) || state_q == WAIT_RSP);
`ifdef DMEM_TIMEOUT_EN
  logic expired, err_q;
  dmem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .rst_n(rst_n),
    .clear(state_q != WAIT_RSP), .inc(state_q == WAIT_RSP), .expired(expired)
  );
  assign timeout = state_q == WAIT_RSP && expired && !bus_rsp_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  assign bus_err = err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = access ? REQ : IDLE;
      REQ:      state_d = !bus_req_ready ? REQ : bus_rsp_valid ? DONE : WAIT_RSP;
      WAIT_RSP: state_d = (bus_rsp_valid || timeout) ? DONE : WAIT_RSP;
      default:  state_d = IDLE;
    endcase
  end
  assign bus_req_valid = state_q == REQ;
  assign core_stall    = capture || state_q == REQ || state_q == WAIT_RSP;
  // Write acks never disturb the last load result.
  assign rdata_d = timeout ? DW'(DMEM_ERR_DATA) : (rsp_take && !we_q) ? bus_rsp_data : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= core_wr;
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
      end
    end
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign core_rdata    = rdata_q;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: table-driven transactions against a scripted memory, plus reset/timeout sequences.
module tb_dmem_bus_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, core_rdata;
  logic        core_stall, bus_req_valid, bus_req_ready = 1'b0, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_data = '0;
  logic        bus_rsp_valid = 1'b0, bus_err;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .core_rd(core_rd), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_err(bus_err)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata, rsp_data;
    int          rdy_wait, rsp_wait;
    bit          same, stray;
    int          exp_stalls;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rdy_wait: REQ cycles with ready low; rsp_wait: WAIT_RSP cycle carrying rsp (0 = never).
  task automatic run(input string name, input vec_t v);
    int stalls = 0, vcyc = 0, wcyc = 0, accepts = 0, cyc = 0;
    bit accepted = 0, done = 0, addr_ok = 1;
    core_rd = v.rd; core_wr = v.wr; core_addr = v.addr; core_wdata = v.wdata;
    while (!done && cyc < 200) begin
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'h0;
      #1;
      if (!core_stall && cyc > 0) begin
        done = 1;
      end else begin
        stalls++;
        if (bus_req_valid) begin
          if (bus_req_addr !== v.addr || bus_req_wdata !== v.wdata || bus_req_we !== v.exp_we) addr_ok = 0;
          if (vcyc >= v.rdy_wait) begin
            bus_req_ready = 1'b1; accepts++; accepted = 1;
            if (v.same) begin bus_rsp_valid = 1'b1; bus_rsp_data = v.rsp_data; end
          end else if (v.stray) begin
            bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEAD_DEAD;
          end
          vcyc++;
        end else if (accepted) begin
          wcyc++;
          if (wcyc == v.rsp_wait) begin bus_rsp_valid = 1'b1; bus_rsp_data = v.rsp_data; end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: stall never released (expected %0d stalls)", name, v.exp_stalls);
    end else begin
      check({name, " stalls"}, stalls, v.exp_stalls);
      check({name, " accepts"}, accepts, 1);
      check({name, " req stable"}, {31'b0, addr_ok}, 1);
      check({name, " rdata"}, core_rdata, v.exp_rdata);
      check({name, " valid in DONE"}, {31'b0, bus_req_valid}, 0);
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'h40, 32'h0,    32'h1234_5678, 0, 1, 0, 0, 3, 0, 32'h1234_5678};
    vecs[1] = '{0, 1, 32'h44, 32'hCAFE, 32'h0,         5, 1, 0, 0, 8, 1, 32'h1234_5678};
    vecs[2] = '{1, 0, 32'h48, 32'h0,    32'hA5A5_0001, 0, 0, 1, 0, 2, 0, 32'hA5A5_0001};
    vecs[3] = '{1, 1, 32'h4C, 32'h11,   32'hFFFF_0000, 0, 2, 0, 0, 4, 1, 32'hA5A5_0001};
    vecs[4] = '{1, 0, 32'h53, 32'h0,    32'h0BAD_F00D, 2, 3, 0, 1, 7, 0, 32'h0BAD_F00D};
    vecs[5] = '{1, 0, 32'h100, 32'h0,   32'h0000_0077, 0, 1, 0, 0, 3, 0, 32'h0000_0077};
    vecs[6] = '{0, 1, 32'h104, 32'h9,   32'h5555_5555, 0, 0, 1, 0, 2, 1, 32'h0000_0077};
    #1;
    check("reset valid", {31'b0, bus_req_valid}, 0);
    check("reset stall", {31'b0, core_stall}, 0);
    check("reset addr", bus_req_addr, 0);
    check("reset we/err", {30'b0, bus_req_we, bus_err}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h99;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("idle rsp ignored", core_rdata, 0);
    for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), vecs[i]);
    core_rd = 1'b0; core_wr = 1'b0;
    @(negedge clk);
    check("idle no stall", {31'b0, core_stall}, 0);
    // reset while waiting for a read response
    core_rd = 1'b1; core_addr = 32'h200;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0; #1;
    check("wait state stall", {30'b0, core_stall, bus_req_valid}, 32'h2);
    rst_n = 1'b0; core_rd = 1'b0; #1;
    check("async reset valid", {31'b0, bus_req_valid}, 0);
    check("async reset addr", bus_req_addr, 0);
    check("async reset rdata", core_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_data = 32'h5555_AAAA;
    @(negedge clk);
    bus_rsp_valid = 1'b0; #1;
    check("late rsp ignored", core_rdata, 0);
    check("late rsp stall/valid", {30'b0, core_stall, bus_req_valid}, 0);
    @(negedge clk);
`ifdef DMEM_TIMEOUT_EN
    run("timeout", '{1, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0, 6, 0, 32'hDEAD_BEEF});
    check("timeout err", {31'b0, bus_err}, 1);
    core_rd = 1'b0;
    @(negedge clk);
    check("timeout err sticky", {31'b0, bus_err}, 1);
`else
    check("err tied low", {31'b0, bus_err}, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
